// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store control stage.
//   - ctr codes (access size in ctr[1:0], zero-extend flag in ctr[2])
//   - response error codes
//   - state machine encodings
//   - ctr_legal(): true for the five supported access codes
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t REQ  = 2'd1;
    localparam state_t WAIT = 2'd2;
    localparam state_t RESP = 2'd3;

    function automatic logic ctr_legal(input logic [2:0] ctr);
        logic ok;
        case (ctr)
            LB, LH, LW, LBU, LHU: ok = 1'b1;
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational access checks and byte-lane handling.
//   ctr        in  access code (size in [1:0], zero-extend in [2])
//   off        in  byte offset within the word (addr[1:0])
//   wdata      in  right-justified store data
//   rdata      in  word read from the bus
//   illegal    out ctr is not a supported code
//   misalign   out access does not fit its natural alignment
//   lane_wdata out store data replicated across the lanes
//   lane_wstrb out byte strobes for the store
//   load_data  out extracted and extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  ctr,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        illegal,
    output logic        misalign,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_wstrb,
    output logic [31:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sext;

    assign illegal = ~ctr_legal(ctr);
    assign sext    = ~ctr[2];

    always_comb begin
        misalign = 1'b0;
        case (ctr[1:0])
            2'b01:   misalign = off[0];
            2'b10:   misalign = |off;
            default: misalign = 1'b0;
        endcase
    end

    always_comb begin
        lane_wdata = wdata;
        lane_wstrb = 4'b1111;
        case (ctr[1:0])
            2'b00: begin
                lane_wdata = {4{wdata[7:0]}};
                lane_wstrb = 4'b0001 << off;
            end
            2'b01: begin
                lane_wdata = {2{wdata[15:0]}};
                lane_wstrb = 4'b0011 << off;
            end
            default: begin
                lane_wdata = wdata;
                lane_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (off)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (ctr[1:0])
            2'b00:   load_data = {{24{sext & byte_v[7]}}, byte_v};
            2'b01:   load_data = {{16{sext & half_v[15]}}, half_v};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage between execute and the data-memory bus.
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      operation handshake from execute (ready only in IDLE)
//   req_we/ctr/addr/wdata    operation fields, latched on acceptance
//   mem_req/gnt              bus request handshake
//   mem_we/addr/wdata/wstrb  bus command, zero outside REQ
//   mem_rvalid/rdata         bus completion (read data or write ack)
//   resp_valid/ready         response handshake to writeback
//   resp_rdata/err           extended load data and error code, held until taken
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_ctr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err
);

    state_t             state_q, state_d;
    logic               we_q;
    logic [2:0]         ctr_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic [1:0]         resp_err_q, resp_err_d;

    logic               accept;
    logic               timeout;
    logic               in_req;
    logic [2:0]         sel_ctr;
    logic [1:0]         sel_off;
    logic               illegal, misalign;
    logic [31:0]        lane_wdata, load_data;
    logic [3:0]         lane_wstrb;

    assign accept  = req_valid & (state_q == IDLE);
    assign timeout = (cnt_q == CNT_W'(MAX_WAIT));
    assign in_req  = (state_q == REQ);

    // Checks must see the incoming request in IDLE; afterwards the latched copy drives
    // lane selection and load extraction.
    assign sel_ctr = (state_q == IDLE) ? req_ctr : ctr_q;
    assign sel_off = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];

    lsu_align u_align (
        .ctr        (sel_ctr),
        .off        (sel_off),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .illegal    (illegal),
        .misalign   (misalign),
        .lane_wdata (lane_wdata),
        .lane_wstrb (lane_wstrb),
        .load_data  (load_data)
    );

    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        state_d      = RESP;
                        resp_err_d   = ERR_ILLEGAL;
                        resp_rdata_d = '0;
                    end else if (misalign) begin
                        state_d      = RESP;
                        resp_err_d   = ERR_MISALIGN;
                        resp_rdata_d = '0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Completion is checked before the timeout so a last-cycle ack still wins.
                if (mem_gnt && mem_rvalid) begin
                    state_d      = RESP;
                    resp_err_d   = ERR_OK;
                    resp_rdata_d = we_q ? '0 : load_data;
                end else if (timeout) begin
                    state_d      = RESP;
                    resp_err_d   = ERR_TIMEOUT;
                    resp_rdata_d = '0;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d      = RESP;
                    resp_err_d   = ERR_OK;
                    resp_rdata_d = we_q ? '0 : load_data;
                end else if (timeout) begin
                    state_d      = RESP;
                    resp_err_d   = ERR_TIMEOUT;
                    resp_rdata_d = '0;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            ctr_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_OK;
        end else begin
            state_q      <= state_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            if (accept) begin
                we_q    <= req_we;
                ctr_q   <= req_ctr;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            // REQ is only entered from IDLE, so clearing outside REQ/WAIT restarts the count.
            if (state_q == REQ || state_q == WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign mem_req    = in_req;
    assign mem_we     = in_req & we_q;
    assign mem_addr   = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata  = (in_req & we_q) ? lane_wdata : 32'd0;
    assign mem_wstrb  = (in_req & we_q) ? lane_wstrb : 4'b0000;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: transaction-level model computing the per-cycle schedule and
// results of each access, compared against the DUT every cycle on the falling edge.
module tb_lsu_ctrl;

    localparam int unsigned TB_MAX_WAIT = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_ctr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    lsu_ctrl #(
        .MAX_WAIT (TB_MAX_WAIT),
        .CNT_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_ctr    (req_ctr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle behaviour, set by the driver at the start of each cycle.
    logic        chk_en = 1'b0;
    logic        exp_req_ready, exp_mem_req, exp_resp_valid, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_wstrb;
    logic [1:0]  exp_err;
    // Hand-computed literals pinning the model on directed cases.
    logic        lit_mem_en = 1'b0, lit_resp_en = 1'b0;
    logic [31:0] lit_addr, lit_wdata, lit_rdata;
    logic [3:0]  lit_wstrb;
    logic [1:0]  lit_err;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] m_err(input logic [2:0] ctr, input logic [31:0] addr);
        int nbytes;
        if (!(ctr inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 2'b11;
        nbytes = 1 << ctr[1:0];
        if ((addr % nbytes) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] ctr, input logic [31:0] addr,
                                           input logic [31:0] rd);
        int nbits;
        logic [63:0] mask, v;
        nbits = 8 << ctr[1:0];
        mask  = (64'd1 << nbits) - 64'd1;
        v     = ({32'd0, rd} >> (8 * addr[1:0])) & mask;
        if (!ctr[2] && v[nbits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] ctr, input logic [31:0] wd);
        if (ctr[1:0] == 2'b00) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (ctr[1:0] == 2'b01) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] ctr, input logic [31:0] addr);
        int n;
        int s;
        n = 1 << ctr[1:0];
        s = ((1 << n) - 1) << addr[1:0];
        return s[3:0];
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", req_ready, exp_req_ready);
            chk("mem_req", mem_req, exp_mem_req);
            if (exp_mem_req) begin
                chk("mem_we", mem_we, exp_we);
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_wstrb", mem_wstrb, exp_wstrb);
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
                if (lit_mem_en) begin
                    chk("lit_mem_addr", mem_addr, lit_addr);
                    chk("lit_mem_wstrb", mem_wstrb, lit_wstrb);
                    if (exp_we) chk("lit_mem_wdata", mem_wdata, lit_wdata);
                end
            end else begin
                chk("idle_mem_addr", mem_addr, 32'd0);
                chk("idle_mem_wstrb", mem_wstrb, 4'd0);
                chk("idle_mem_we", mem_we, 1'b0);
                chk("idle_mem_wdata", mem_wdata, 32'd0);
            end
            chk("resp_valid", resp_valid, exp_resp_valid);
            if (exp_resp_valid) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", resp_err, exp_err);
                if (lit_resp_en) begin
                    chk("lit_resp_rdata", resp_rdata, lit_rdata);
                    chk("lit_resp_err", resp_err, lit_err);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic set_idle_exp();
        exp_req_ready  = 1'b1;
        exp_mem_req    = 1'b0;
        exp_resp_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic stale_rvalid);
        for (int i = 0; i < n; i++) begin
            req_valid  = 1'b0;
            req_we     = 1'($urandom_range(0, 1));
            req_ctr    = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            mem_gnt    = 1'($urandom_range(0, 1));
            mem_rvalid = stale_rvalid ? 1'b1 : 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            resp_ready = 1'($urandom_range(0, 1));
            set_idle_exp();
            @(posedge clk); #1;
        end
    endtask

    // One access: g = cycles gnt is held low in REQ, r = cycles from gnt to rvalid
    // (0 = same cycle), rdy = cycles resp_ready is held low once the response is up.
    // Cycle 0 is the acceptance cycle.
    task automatic run_txn(input logic we, input logic [2:0] ctr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int g, input int r, input int rdy);
        logic [1:0] err;
        int t_gnt, t_cmp, t_req_end, t_resp, deadline;
        err      = m_err(ctr, addr);
        deadline = 1 + int'(TB_MAX_WAIT);
        t_gnt    = 1 + g;
        t_cmp    = t_gnt + r;
        if (err != 2'b00) begin
            t_req_end = 0;
            t_resp    = 1;
        end else if (t_gnt > deadline) begin
            t_req_end = deadline;
            t_resp    = deadline + 1;
            err       = 2'b10;
        end else begin
            t_req_end = t_gnt;
            if (t_cmp <= deadline) begin
                t_resp = t_cmp + 1;
            end else begin
                t_resp = deadline + 1;
                err    = 2'b10;
            end
        end
        exp_we    = we;
        exp_addr  = {addr[31:2], 2'b00};
        exp_wdata = m_wdata(ctr, wd);
        exp_wstrb = we ? m_wstrb(ctr, addr) : 4'b0000;
        exp_err   = err;
        exp_rdata = (err == 2'b00 && !we) ? m_load(ctr, addr, rd) : 32'd0;

        for (int k = 0; k <= t_resp + rdy; k++) begin
            if (k == 0) begin
                req_valid = 1'b1;
                req_we    = we;
                req_ctr   = ctr;
                req_addr  = addr;
                req_wdata = wd;
            end else begin
                // Execute inputs are don't-care once the request is latched.
                req_valid = 1'($urandom_range(0, 1));
                req_we    = 1'($urandom_range(0, 1));
                req_ctr   = 3'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
            end
            exp_req_ready  = (k == 0);
            exp_mem_req    = (k >= 1 && k <= t_req_end);
            exp_resp_valid = (k >= t_resp);
            if (exp_mem_req) mem_gnt = (k == t_gnt);
            else             mem_gnt = 1'($urandom_range(0, 1));
            if (k >= 1 && k < t_resp) mem_rvalid = (k == t_cmp);
            else                      mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata = (k == t_cmp) ? rd : $urandom;
            if (k >= t_resp) resp_ready = (k >= t_resp + rdy);
            else             resp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    logic [2:0] legal_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_ctr    = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        resp_ready = 1'b0;
        set_idle_exp();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_wstrb", mem_wstrb, 4'd0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", resp_err, 2'b00);
        chk_en = 1'b1;
        @(posedge clk); #1;

        // lbu at 0x80000003, gnt+rvalid in the first REQ cycle.
        lit_mem_en = 1'b1; lit_addr = 32'h8000_0000; lit_wstrb = 4'b0000; lit_wdata = 32'd0;
        lit_resp_en = 1'b1; lit_rdata = 32'h0000_008A; lit_err = 2'b00;
        run_txn(1'b0, 3'b100, 32'h8000_0003, 32'd0, 32'h8A00_0000, 0, 0, 0);
        lit_addr = 32'h8000_0000; lit_rdata = 32'hFFFF_F234;
        run_txn(1'b0, 3'b001, 32'h8000_0002, 32'd0, 32'hF234_5678, 0, 0, 0);
        lit_rdata = 32'h0000_F234;
        run_txn(1'b0, 3'b101, 32'h8000_0002, 32'd0, 32'hF234_5678, 1, 1, 0);
        // sb with gnt held low for 3 cycles.
        lit_wdata = 32'hABAB_ABAB; lit_wstrb = 4'b0010; lit_rdata = 32'd0;
        run_txn(1'b1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 32'hDEAD_BEEF, 3, 1, 0);
        lit_mem_en = 1'b0;
        // Errors: misaligned lw, then illegal code at an aligned address.
        lit_err = 2'b01;
        run_txn(1'b0, 3'b010, 32'h8000_0002, 32'd0, 32'd0, 0, 0, 0);
        lit_err = 2'b11;
        run_txn(1'b0, 3'b011, 32'h8000_0000, 32'd0, 32'd0, 0, 0, 0);
        // Timeout: gnt but no rvalid; then a stale rvalid in IDLE.
        lit_err = 2'b10;
        run_txn(1'b0, 3'b010, 32'h8000_0010, 32'd0, 32'd0, 0, 100, 0);
        lit_resp_en = 1'b0;
        idle(3, 1'b1);
        // Completion in the same cycle the counter reaches MAX_WAIT finishes ok.
        run_txn(1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'h1357_9BDF, 1, 3, 0);
        // Response held with resp_ready low for 3 cycles.
        run_txn(1'b0, 3'b000, 32'h0000_0005, 32'd0, 32'h0000_F000, 0, 2, 3);

        // Reset while in WAIT: access abandoned, no response, stale rvalid ignored.
        req_valid = 1'b1; req_we = 1'b0; req_ctr = 3'b010; req_addr = 32'h1000_0010;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; resp_ready = 1'b1;
        set_idle_exp();
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_req_ready = 1'b0; exp_mem_req = 1'b1; exp_we = 1'b0;
        exp_addr = 32'h1000_0010; exp_wstrb = 4'b0000;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; exp_mem_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle_exp();
        mem_rvalid = 1'b1;
        #3;
        chk("rstmid_resp_rdata", resp_rdata, 32'd0);
        chk("rstmid_resp_err", resp_err, 2'b00);
        @(posedge clk); #1;
        idle(2, 1'b1);

        // Randomized accesses.
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  c;
            logic [31:0] a;
            if ($urandom_range(0, 9) < 8) c = legal_codes[$urandom_range(0, 4)];
            else                          c = 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_txn(1'($urandom_range(0, 1)), c, a, $urandom, $urandom,
                    $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 2));
            idle($urandom_range(0, 2), 1'b0);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
